// File: rtl/instr_fetch_unit.sv
// Non-pipelined instruction fetch stage: PC register, imem request/response sequencing, instruction hand-off.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (trap misaligned redirect targets instead of aligning them).
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [2:0]  funct_3,
  output logic [6:0]  funct_7,
  output logic [31:0] pc,
  output logic [31:0] pc_plus_4,
  input  logic        pc_src,
  input  logic [31:0] pc_target,
  output logic        fetch_fault
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [31:0] pc_r;
  logic [31:0] pc_s;
  logic [31:0] instr_r;
  logic [31:0] instr_s;
  logic [31:0] pc_inc_s;
  logic        req_valid_r;
  logic        instr_valid_r;

  assign pc_inc_s = pc_r + 32'd4;

  // Next-state, next-PC and instruction capture.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    instr_s = instr_r;
    case (state_r)
      ST_IDLE: begin
        state_s = ST_REQ;
      end
      ST_REQ: begin
        if (imem_req_ready) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          instr_s = imem_rsp_data;
          state_s = ST_HOLD;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (instr_ready) begin
          if (pc_src) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            // The raw target is kept in pc so a debugger can see what faulted.
            pc_s = pc_target;
            if (pc_target[1:0] != 2'b00) begin
              state_s = ST_FAULT;
            end else begin
              state_s = ST_REQ;
            end
`else
            pc_s    = pc_target & 32'hFFFF_FFFC;
            state_s = ST_REQ;
`endif
          end else begin
            pc_s    = pc_inc_s;
            state_s = ST_REQ;
          end
        end else begin
          state_s = ST_HOLD;
        end
      end
      ST_FAULT: begin
        state_s = ST_FAULT;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, PC, instruction and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      pc_r          <= RESET_PC;
      instr_r       <= NOP_INSTR;
      req_valid_r   <= 1'b0;
      instr_valid_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      pc_r          <= pc_s;
      instr_r       <= instr_s;
      req_valid_r   <= (state_s == ST_REQ);
      instr_valid_r <= (state_s == ST_HOLD);
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_r;

  // Sticky fault flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fault_r <= 1'b0;
    end else begin
      fault_r <= (state_s == ST_FAULT);
    end
  end

  assign fetch_fault = fault_r;
`else
  assign fetch_fault = 1'b0;
`endif

  assign imem_req_valid = req_valid_r;
  assign imem_req_addr  = pc_r;
  assign instr_valid    = instr_valid_r;
  assign instr          = instr_r;
  assign opcode         = instr_r[6:0];
  assign funct_3        = instr_r[14:12];
  assign funct_7        = instr_r[31:25];
  assign pc             = pc_r;
  assign pc_plus_4      = pc_inc_s;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized fetches against a transaction-level model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct_3;
  logic [6:0]  funct_7;
  logic [31:0] pc;
  logic [31:0] pc_plus_4;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        fetch_fault;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int hold_cyc = 0;

  logic [31:0] exp_pc;
  logic [31:0] exp_instr;
  logic        exp_fault;

  instr_fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .opcode(opcode), .funct_3(funct_3), .funct_7(funct_7),
    .pc(pc), .pc_plus_4(pc_plus_4), .pc_src(pc_src), .pc_target(pc_target),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete fetch starting at a negedge with the DUT requesting exp_pc.
  task automatic fetch_one(input int req_dly, input int rsp_dly, input int rdy_dly,
                           input logic src, input logic [31:0] tgt, input logic [31:0] data);
    check("req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("req_addr", imem_req_addr, exp_pc);
    for (int i = 0; i < req_dly; i++) begin
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'($urandom_range(0, 1));
      imem_rsp_data  = $urandom;
      @(negedge clk);
      check("req_stall_valid", {31'd0, imem_req_valid}, 32'd1);
      check("req_stall_addr", imem_req_addr, exp_pc);
      check("req_stall_instr", instr, exp_instr);
    end
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    @(negedge clk);
    imem_req_ready = 1'b0;
    for (int i = 0; i < rsp_dly; i++) begin
      check("wait_req_valid", {31'd0, imem_req_valid}, 32'd0);
      check("wait_instr_valid", {31'd0, instr_valid}, 32'd0);
      @(negedge clk);
    end
    check("wait_req_valid", {31'd0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    exp_instr = data;
    hold_cyc  = cyc;
    check("hold_valid", {31'd0, instr_valid}, 32'd1);
    check("instr", instr, exp_instr);
    check("opcode", {25'd0, opcode}, {25'd0, data[6:0]});
    check("funct_3", {29'd0, funct_3}, {29'd0, data[14:12]});
    check("funct_7", {25'd0, funct_7}, {25'd0, data[31:25]});
    check("pc", pc, exp_pc);
    check("pc_plus_4", pc_plus_4, exp_pc + 32'd4);
    for (int i = 0; i < rdy_dly; i++) begin
      instr_ready    = 1'b0;
      pc_src         = 1'b1;
      pc_target      = $urandom;
      imem_rsp_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("hold_stall_valid", {31'd0, instr_valid}, 32'd1);
      check("hold_stall_instr", instr, exp_instr);
      check("hold_stall_pc", pc, exp_pc);
      check("hold_stall_req", {31'd0, imem_req_valid}, 32'd0);
    end
    instr_ready    = 1'b1;
    pc_src         = src;
    pc_target      = tgt;
    imem_rsp_valid = 1'b0;
    @(negedge clk);
    instr_ready = 1'b0;
    pc_src      = 1'b1;
    pc_target   = $urandom;
    if (src) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      exp_pc    = tgt;
      exp_fault = (tgt % 32'd4) != 32'd0;
`else
      exp_pc = tgt - (tgt % 32'd4);
`endif
    end else begin
      exp_pc = exp_pc + 32'd4;
    end
    check("post_instr_valid", {31'd0, instr_valid}, 32'd0);
    check("post_fault", {31'd0, fetch_fault}, {31'd0, exp_fault});
    check("post_pc", pc, exp_pc);
  endtask

  initial begin
    int prev_hold;
    rst_n = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    instr_ready    = 1'b0;
    pc_src         = 1'b0;
    pc_target      = 32'd0;
    exp_pc    = RST_PC;
    exp_instr = NOP;
    exp_fault = 1'b0;

    // Reset held three cycles, then one idle cycle before the first request.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, NOP);
    check("rst_pc", pc, RST_PC);
    check("rst_fault", {31'd0, fetch_fault}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle_req_valid", {31'd0, imem_req_valid}, 32'd0);
    @(negedge clk);

    // Straight-line code with zero-wait memory: instr_valid pulses 3 cycles apart.
    fetch_one(0, 0, 0, 1'b0, 32'd0, 32'h0000_0093);
    prev_hold = hold_cyc;
    fetch_one(0, 0, 0, 1'b0, 32'd0, 32'h0010_0113);
    check("pulse_spacing", hold_cyc - prev_hold, 32'd3);

    // Taken branch, with pc_src held high during the stall before the handshake.
    fetch_one(0, 1, 2, 1'b1, 32'h0000_0100, $urandom);
    check("branch_addr", imem_req_addr, 32'h0000_0100);

    // Backpressure on both request and instruction channels.
    fetch_one(4, 2, 5, 1'b0, 32'd0, $urandom);

    // PC wrap at the top of the address space.
    fetch_one(0, 0, 0, 1'b1, 32'hFFFF_FFFC, $urandom);
    fetch_one(1, 0, 1, 1'b0, 32'd0, $urandom);
    check("wrap_addr", imem_req_addr, 32'h0000_0000);

    // Reset while a response is outstanding; the late response must be discarded.
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    check("rw_wait", {31'd0, imem_req_valid}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rw_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("rw_addr", imem_req_addr, RST_PC);
    check("rw_instr", instr, NOP);
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    check("rw_instr_late", instr, NOP);
    check("rw_still_req", {31'd0, imem_req_valid}, 32'd1);
    exp_pc    = RST_PC;
    exp_instr = NOP;

    // Randomized fetch sequence.
    for (int n = 0; n < 30; n++) begin
      logic        src;
      logic [31:0] tgt;
      src = ($urandom_range(0, 2) == 0);
      tgt = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
      tgt = tgt & 32'hFFFF_FFFC;
`endif
      fetch_one($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), src, tgt, $urandom);
    end

    // Misaligned redirect target.
    fetch_one(0, 0, 0, 1'b1, 32'h0000_0102, $urandom);
`ifdef FETCH_MISALIGN_TRAP_EN
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b1;
    instr_ready    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("fault_sticky", {31'd0, fetch_fault}, 32'd1);
      check("fault_no_req", {31'd0, imem_req_valid}, 32'd0);
      check("fault_no_instr", {31'd0, instr_valid}, 32'd0);
    end
`else
    check("misalign_addr", imem_req_addr, 32'h0000_0100);
    check("misalign_no_fault", {31'd0, fetch_fault}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
